// File: rtl/wptr_ctrl_if.sv
// Write-port bundle of the async FIFO write-side pointer controller.
// Handshake: a write happens in any cycle where w_en and w_accept are both high; w_en may drop at any time.
interface wptr_ctrl_if #(
  parameter int PTR_WIDTH = 3
);
  logic                 w_en;
  logic [PTR_WIDTH:0]   g_rptr_sync;
  logic [PTR_WIDTH:0]   af_thresh;
  logic                 clr_ovf;
  logic                 w_accept;
  logic [PTR_WIDTH-1:0] waddr;
  logic [PTR_WIDTH:0]   b_wptr;
  logic [PTR_WIDTH:0]   g_wptr;
  logic [PTR_WIDTH:0]   wlevel;
  logic                 full;
  logic                 almost_full;
  logic                 overflow;

  modport master (
    output w_en, g_rptr_sync, af_thresh, clr_ovf,
    input  w_accept, waddr, b_wptr, g_wptr, wlevel, full, almost_full, overflow
  );

  modport slave (
    input  w_en, g_rptr_sync, af_thresh, clr_ovf,
    output w_accept, waddr, b_wptr, g_wptr, wlevel, full, almost_full, overflow
  );
endinterface

// File: rtl/wptr_ctrl.sv
// Write-side pointer controller: binary/Gray write pointers, fill level, full,
// almost-full and sticky overflow, all in the wclk domain.
module wptr_ctrl #(
  parameter int PTR_WIDTH = 3
) (
  input  logic          wclk,
  input  logic          wrst,
  wptr_ctrl_if.slave    bus
);
  localparam int PW = PTR_WIDTH + 1;

  logic [PW-1:0] b_wptr_q, g_wptr_q, wlevel_q;
  logic          full_q, almost_full_q, overflow_q;

  logic          w_accept;
  logic [PW-1:0] b_wptr_next, g_wptr_next, b_rptr, level_next;
  logic          full_next, almost_full_next;

  // Writes are also refused while reset is held so nothing is reported as accepted then.
  assign w_accept    = bus.w_en & ~full_q & ~wrst;
  assign b_wptr_next = b_wptr_q + {{PTR_WIDTH{1'b0}}, w_accept};
  assign g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;

  always_comb begin
    b_rptr            = '0;
    b_rptr[PW-1]      = bus.g_rptr_sync[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b_rptr[i] = b_rptr[i+1] ^ bus.g_rptr_sync[i];
    end
  end

  assign level_next       = b_wptr_next - b_rptr;
  // Full when the Gray pointers differ only in their two top bits.
  assign full_next        = (g_wptr_next == {~bus.g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                                             bus.g_rptr_sync[PTR_WIDTH-2:0]});
  assign almost_full_next = (level_next >= bus.af_thresh);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      b_wptr_q      <= '0;
      g_wptr_q      <= '0;
      wlevel_q      <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      b_wptr_q      <= b_wptr_next;
      g_wptr_q      <= g_wptr_next;
      wlevel_q      <= level_next;
      full_q        <= full_next;
      almost_full_q <= almost_full_next;
      // A dropped write outranks a clear in the same cycle.
      if (bus.w_en && full_q) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.w_accept    = w_accept;
  assign bus.waddr       = b_wptr_q[PTR_WIDTH-1:0];
  assign bus.b_wptr      = b_wptr_q;
  assign bus.g_wptr      = g_wptr_q;
  assign bus.wlevel      = wlevel_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.overflow    = overflow_q;
endmodule
